// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW       = 8;
    localparam int DEF_DW       = 8;
    localparam int DEF_MAX_HOLD = 4;

    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    function automatic owner_e own_of(input logic id);
        return id ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled with
// master (requesters + memory) and slave (arbiter) views.
interface mem_bus_arbiter_if #(
    parameter int AW = mem_arb_pkg::DEF_AW,
    parameter int DW = mem_arb_pkg::DEF_DW
);
    logic [1:0]      req;
    logic [1:0]      lock;
    logic [1:0]      we;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] wdata;
    logic [1:0]      gnt;
    logic [1:0]      rvalid;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_address;
    logic            mem_write;
    logic [DW-1:0]   mem_data_in;
    logic [DW-1:0]   mem_data_out;

    modport master (
        output req, lock, we, addr, wdata, mem_data_out,
        input  gnt, rvalid, rdata, mem_address, mem_write, mem_data_in
    );

    modport slave (
        input  req, lock, we, addr, wdata, mem_data_out,
        output gnt, rvalid, rdata, mem_address, mem_write, mem_data_in
    );
endinterface

// File: rtl/mem_arb_pick.sv
// Next-owner decision: round-robin on ties, forced switch after MAX_HOLD
// granted cycles unless the owner holds lock.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int HW       = 1
) (
    input  owner_e        owner_q_i,
    input  logic          last_q_i,
    input  logic [HW-1:0] hold_q_i,
    input  logic [1:0]    req_i,
    input  logic [1:0]    lock_i,
    output owner_e        owner_d_o,
    output logic          hold_clr_o
);
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

    logic o;
    logic x;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        owner_d_o = owner_q_i;
        o         = 1'b0;
        x         = 1'b1;
        case (owner_q_i)
            IDLE: begin
                if (&req_i)        owner_d_o = own_of(~last_q_i);
                else if (req_i[0]) owner_d_o = OWN0;
                else if (req_i[1]) owner_d_o = OWN1;
            end
            OWN0, OWN1: begin
                o = (owner_q_i == OWN1);
                x = ~o;
                if (!req_i[o]) begin
                    owner_d_o = req_i[x] ? own_of(x) : IDLE;
                end else if (req_i[x] && !lock_i[o] && (hold_q_i == HOLD_TOP)) begin
                    owner_d_o = own_of(x);
                end
            end
            default: owner_d_o = IDLE;
        endcase
    end

    assign hold_clr_o = (owner_d_o != owner_q_i);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between cpu (req 0) and dma (req 1); holds owner,
// hold counter and read-pending pipeline, and muxes the granted requester.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_TOP = HW'(MAX_HOLD - 1);

    owner_e        owner_q, owner_d;
    logic          last_q, last_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    rd_pend_q, rd_pend_d;
    logic          hold_clr;
    logic [1:0]    gnt;

    mem_arb_pick #(.MAX_HOLD(MAX_HOLD), .HW(HW)) u_pick (
        .owner_q_i  (owner_q),
        .last_q_i   (last_q),
        .hold_q_i   (hold_q),
        .req_i      (bus.req),
        .lock_i     (bus.lock),
        .owner_d_o  (owner_d),
        .hold_clr_o (hold_clr)
    );

    always_comb begin
        last_d = last_q;
        hold_d = hold_q;
        if (hold_clr) begin
            hold_d = '0;
            if (owner_d == OWN0)      last_d = 1'b0;
            else if (owner_d == OWN1) last_d = 1'b1;
        end else if ((|gnt) && (hold_q != HOLD_TOP)) begin
            hold_d = hold_q + HW'(1);
        end
        rd_pend_d = gnt & ~bus.we;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            owner_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= '0;
            rd_pend_q <= '0;
        end else begin
            owner_q   <= owner_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
        end
    end

    // Grant is gated by reset so nothing reaches memory while reset is held.
    always_comb begin
        gnt             = '0;
        gnt[REQ_CPU]    = (owner_q == OWN0) && bus.req[REQ_CPU] && !reset;
        gnt[REQ_DMA]    = (owner_q == OWN1) && bus.req[REQ_DMA] && !reset;
        bus.mem_address = '0;
        bus.mem_data_in = '0;
        bus.mem_write   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i]) begin
                bus.mem_address = bus.addr[i*AW +: AW];
                bus.mem_data_in = bus.wdata[i*DW +: DW];
                bus.mem_write   = bus.we[i];
            end
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = reset ? 2'b00 : rd_pend_q;
    assign bus.rdata  = bus.mem_data_out;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: single read, contention, lock, write mux, handoff and
// reset mid-read, against a 1-cycle registered memory model.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] mem [256];

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory with registered read; address 8'h10 is preloaded while reset is held.
    always @(posedge clk) begin
        if (reset) mem[8'h10] <= 8'h5A;
        else if (bus.mem_write) mem[bus.mem_address] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_address];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;

    initial begin
        reset     = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        bus.we    = '0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (2) next_cycle();

        // Reset: outputs quiet even with requests present
        bus.req   = 2'b11;
        bus.we    = 2'b11;
        bus.addr  = {8'h77, 8'h66};
        bus.wdata = {8'h99, 8'h88};
        sample();
        check("rst_gnt", bus.gnt, 2'b00);
        check("rst_rvalid", bus.rvalid, 2'b00);
        check("rst_mem_write", bus.mem_write, 1'b0);
        check("rst_mem_address", bus.mem_address, 8'h00);
        check("rst_mem_data_in", bus.mem_data_in, 8'h00);
        next_cycle();

        // 1: single cpu read of 8'h10
        reset    = 1'b0;
        bus.req  = 2'b01;
        bus.we   = 2'b00;
        bus.addr = {8'h00, 8'h10};
        sample();
        check("t1_idle_gnt", bus.gnt, 2'b00);
        next_cycle();
        sample();
        check("t1_gnt", bus.gnt, 2'b01);
        check("t1_addr", bus.mem_address, 8'h10);
        check("t1_we", bus.mem_write, 1'b0);
        next_cycle();
        bus.req = 2'b00;
        sample();
        check("t1_rvalid", bus.rvalid, 2'b01);
        check("t1_rdata", bus.rdata, 8'h5A);
        check("t1_gnt_off", bus.gnt, 2'b00);
        next_cycle();

        // 2: contention from IDLE straight after reset
        reset   = 1'b1;
        bus.req = 2'b00;
        next_cycle();
        reset    = 1'b0;
        bus.req  = 2'b11;
        bus.we   = 2'b00;
        bus.addr = {8'h30, 8'h20};
        sample();
        check("t2_idle_gnt", bus.gnt, 2'b00);
        next_cycle();
        prev_gnt = 2'b00;
        for (int k = 0; k < 12; k++) begin
            exp_gnt = (((k / 4) % 2) == 1) ? 2'b10 : 2'b01;
            sample();
            check($sformatf("t2_gnt_%0d", k), bus.gnt, exp_gnt);
            check($sformatf("t2_addr_%0d", k), bus.mem_address, (exp_gnt == 2'b01) ? 8'h20 : 8'h30);
            if (k > 0) check($sformatf("t2_rvalid_%0d", k), bus.rvalid, prev_gnt);
            prev_gnt = exp_gnt;
            next_cycle();
        end

        // 3: dma owns with lock held through 10 contested cycles
        bus.lock = 2'b10;
        for (int j = 0; j < 10; j++) begin
            sample();
            check($sformatf("t3_lock_%0d", j), bus.gnt, 2'b10);
            next_cycle();
        end
        bus.lock = 2'b00;
        sample();
        check("t3_unlock_cycle", bus.gnt, 2'b10);
        next_cycle();
        sample();
        check("t3_switch", bus.gnt, 2'b01);
        next_cycle();
        bus.req = 2'b00;
        sample();
        check("t3_release_gnt", bus.gnt, 2'b00);
        check("t3_release_we", bus.mem_write, 1'b0);
        next_cycle();

        // 4: dma writes C3 to F0, then reads it back
        bus.req   = 2'b10;
        bus.we    = 2'b10;
        bus.addr  = {8'hF0, 8'h00};
        bus.wdata = {8'hC3, 8'h00};
        sample();
        check("t4_pre_we", bus.mem_write, 1'b0);
        next_cycle();
        sample();
        check("t4_gnt", bus.gnt, 2'b10);
        check("t4_we", bus.mem_write, 1'b1);
        check("t4_addr", bus.mem_address, 8'hF0);
        check("t4_data", bus.mem_data_in, 8'hC3);
        next_cycle();
        bus.req = 2'b00;
        bus.we  = 2'b00;
        sample();
        check("t4_post_we", bus.mem_write, 1'b0);
        check("t4_no_rvalid", bus.rvalid, 2'b00);
        next_cycle();
        bus.req = 2'b10;
        sample();
        check("t4_rd_wait_we", bus.mem_write, 1'b0);
        next_cycle();
        sample();
        check("t4_rd_gnt", bus.gnt, 2'b10);
        check("t4_rd_we", bus.mem_write, 1'b0);
        next_cycle();
        bus.req = 2'b00;
        sample();
        check("t4_rd_rvalid", bus.rvalid, 2'b10);
        check("t4_rd_data", bus.rdata, 8'hC3);
        next_cycle();

        // 5: cpu drops req as dma raises it
        bus.req  = 2'b01;
        bus.addr = {8'hF0, 8'h44};
        next_cycle();
        sample();
        check("t5_cpu_gnt", bus.gnt, 2'b01);
        next_cycle();
        bus.req = 2'b10;
        sample();
        check("t5_drop_gnt", bus.gnt, 2'b00);
        next_cycle();
        sample();
        check("t5_handoff", bus.gnt, 2'b10);
        check("t5_addr", bus.mem_address, 8'hF0);
        next_cycle();

        // 6: reset in the cycle after a granted read
        reset   = 1'b1;
        bus.req = 2'b11;
        sample();
        check("t6_rst_rvalid", bus.rvalid, 2'b00);
        check("t6_rst_gnt", bus.gnt, 2'b00);
        check("t6_rst_we", bus.mem_write, 1'b0);
        next_cycle();
        reset = 1'b0;
        sample();
        check("t6_idle_gnt", bus.gnt, 2'b00);
        check("t6_idle_rvalid", bus.rvalid, 2'b00);
        next_cycle();
        sample();
        check("t6_tie_cpu", bus.gnt, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
